cdc_handshake_src: RTL

//   Source-side controller for a 4-phase req/ack handshake that moves a WIDTH-bit word out of the clk domain.

---
 rtl/cdc_handshake_src.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cdc_handshake_src.sv
// Source side of a 4-phase req/ack handshake that carries a WIDTH-bit word out of the clk domain.
// Includes a two-flop acknowledge synchronizer, a per-phase timeout and a completed-transfer counter.

module dff_meta #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

module cdc_handshake_src #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             xfer_req,
  output logic [WIDTH-1:0] xfer_data,
  input  logic             xfer_ack_async,
  output logic             done,
  output logic             timeout_err,
  output logic [15:0]      xfer_count
);

  localparam int CW         = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] CNT_LAST = CNT_LAST_I[CW-1:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             terr_q, terr_d;
  logic [15:0]      count_q, count_d;
  logic             acked_q, acked_d;
  logic             ack_sync;
  logic             timeout_hit;

  dff_meta #(.WIDTH(1)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (xfer_ack_async),
    .q     (ack_sync)
  );

  // Upstream port: a word moves when in_valid && in_ready are both high at a clk edge.
  // The sender must hold in_valid and in_data until that edge; in_ready never depends on in_valid.
  assign in_ready    = (state_q == IDLE) && !ack_sync;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  assign xfer_req    = req_q;
  assign xfer_data   = data_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign xfer_count  = count_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    terr_d  = terr_q;
    count_d = count_q;
    acked_d = acked_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          req_d   = 1'b1;
          cnt_d   = '0;
          acked_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        // An ack arriving on the timeout cycle still counts as a completed request phase.
        if (ack_sync) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          acked_d = 1'b1;
          state_d = RELEASE;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          terr_d  = 1'b1;
          cnt_d   = '0;
          acked_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        cnt_d = cnt_q + 1'b1;
        // Only a request phase that was acknowledged yields a done pulse and a count.
        if (!ack_sync) begin
          if (acked_q) begin
            done_d  = 1'b1;
            count_d = count_q + 16'd1;
          end
          state_d = IDLE;
        end else if (timeout_hit) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      count_q <= 16'd0;
      acked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      count_q <= count_d;
      acked_q <= acked_d;
    end
  end

endmodule
